// File: rtl/rca_slice_sequencer_pkg.sv
// rca_slice_sequencer_pkg: shared FSM encoding and slice-count helper for the sequential adder.
package rca_slice_sequencer_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;
  function automatic int slice_count(input int n, input int w);
    return n / w;
  endfunction
endpackage

// File: rtl/rca_slice_sequencer_rca_slice.sv
// rca_slice: W-bit ripple-carry adder built from full-adder cells.
module rca_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] s_o,
  output logic         cout_o
);
  logic [W:0] c;
  assign c[0] = cin_i;
  for (genvar g = 0; g < W; g++) begin : g_fa
    assign s_o[g]   = a_i[g] ^ b_i[g] ^ c[g];
    assign c[g+1]   = (a_i[g] & b_i[g]) | (c[g] & (a_i[g] ^ b_i[g]));
  end
  assign cout_o = c[W];
endmodule

// File: rtl/rca_slice_sequencer.sv
// rca_slice_sequencer: N-bit add (optionally subtract with RCA_SEQ_SUB_EN) using one W-bit slice over N/W cycles.
module rca_slice_sequencer
  import rca_slice_sequencer_pkg::*;
#(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] operand_a,
  input  logic [N-1:0] operand_b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         busy
);
  localparam int K  = slice_count(N, W);
  localparam int IW = K > 1 ? $clog2(K) : 1;
  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic           carry_q, carry_d, cout_q, cout_d;
  logic           sub_eff, last, c;
  logic [W-1:0]   s;
`ifdef RCA_SEQ_SUB_EN
  assign sub_eff = sub;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign sub_eff    = 1'b0;
`endif
  assign last = idx_q == IW'(K - 1);
  rca_slice #(.W(W)) u_slice (
    .a_i   (a_q[int'(idx_q)*W +: W]),
    .b_i   (b_q[int'(idx_q)*W +: W]),
    .cin_i (carry_q),
    .s_o   (s),
    .cout_o(c)
  );
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      ST_IDLE: if (in_valid) begin
        a_d     = operand_a;
        b_d     = sub_eff ? ~operand_b : operand_b;
        carry_d = sub_eff;
        idx_d   = '0;
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        sum_d[int'(idx_q)*W +: W] = s;
        carry_d = c;
        idx_d   = last ? '0 : idx_q + 1'b1;
        cout_d  = last ? c : cout_q;
        state_d = last ? ST_DONE : ST_BUSY;
      end
      ST_DONE: state_d = out_ready ? ST_IDLE : ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end
  assign in_ready  = (state_q == ST_IDLE) & ~rst;
  assign out_valid = state_q == ST_DONE;
  assign busy      = state_q != ST_IDLE;
  assign sum       = sum_q;
  assign cout      = cout_q;
endmodule

// File: tb/tb_rca_slice_sequencer.sv
// tb_rca_slice_sequencer: scoreboard bench for the 32-bit / 8-bit-slice sequential adder.
module tb_rca_slice_sequencer;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, sub, out_valid, out_ready, cout, busy;
  logic [31:0] operand_a, operand_b, sum;
  int total = 0, bad = 0;
  typedef struct {logic [31:0] s; logic c;} exp_t;
  exp_t q[$];

  rca_slice_sequencer #(.N(32), .W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .operand_a(operand_a), .operand_b(operand_b), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] s, input logic c);
    exp_t e;
    e.s = s;
    e.c = c;
    q.push_back(e);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sb);
    operand_a = a;
    operand_b = b;
    sub       = sb;
    in_valid  = 1'b1;
    tick;
    in_valid  = 1'b0;
    operand_a = 32'hDEAD_BEEF;
    operand_b = 32'hCAFE_F00D;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick;
      n++;
    end
    if (!out_valid) chk("timeout_out_valid", {63'd0, out_valid}, 64'd1);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result act=%0h exp=none", sum);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sum", {32'd0, sum}, {32'd0, e.s});
        chk("cout", {63'd0, cout}, {63'd0, e.c});
      end
    end
  end

  initial begin
    int n;
    int acc[$];
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0;
    operand_a = '0; operand_b = '0;
    tick; tick;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_sum", {32'd0, sum}, 64'd0);
    chk("rst_cout", {63'd0, cout}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", {63'd0, in_ready}, 64'd1);
    // 1: full carry ripple, latency
    out_ready = 1'b1;
    push(32'h0000_0000, 1'b1);
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    chk("busy_after_accept", {63'd0, busy}, 64'd1);
    wait_done(n);
    chk("latency", 64'(n), 64'd4);
    tick;
    chk("out_valid_drop", {63'd0, out_valid}, 64'd0);
    // 2: inter-slice carry
    push(32'h0000_0100, 1'b0);
    issue(32'h0000_00FF, 32'h0000_0001, 1'b0);
    wait_done(n);
    tick;
    // 3: backpressure and ignored in_valid
    out_ready = 1'b0;
    push(32'h0000_0003, 1'b0);
    issue(32'h0000_0001, 32'h0000_0002, 1'b0);
    operand_a = 32'd99; operand_b = 32'd99; in_valid = 1'b1;
    chk("busy_in_ready", {63'd0, in_ready}, 64'd0);
    tick;
    in_valid = 1'b0;
    wait_done(n);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_sum", {32'd0, sum}, 64'h3);
      tick;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick;
    chk("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
    // 4: reset mid-operation
    issue(32'h0000_000F, 32'h0000_0001, 1'b0);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_sum", {32'd0, sum}, 64'd0);
    tick; tick;
    chk("abort_no_result", {63'd0, out_valid}, 64'd0);
    push(32'h0000_0007, 1'b0);
    issue(32'h0000_0003, 32'h0000_0004, 1'b0);
    wait_done(n);
    tick;
    // 5: sub request
`ifdef RCA_SEQ_SUB_EN
    push(32'hFFFF_FFFE, 1'b0);
`else
    push(32'h0000_000C, 1'b0);
`endif
    issue(32'h0000_0005, 32'h0000_0007, 1'b1);
    sub = 1'b0;
    wait_done(n);
    tick;
    // 6: back-to-back
    operand_a = 32'h1234_5678; operand_b = 32'h1111_1111; in_valid = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (in_ready) begin
        acc.push_back(c);
        push(32'h2345_6789, 1'b0);
      end
      tick;
    end
    in_valid = 1'b0;
    chk("b2b_accepts", 64'(acc.size()), 64'd3);
    if (acc.size() >= 2) chk("b2b_gap", 64'(acc[1] - acc[0]), 64'd6);
    n = 0;
    while (q.size() != 0 && n < 40) begin
      tick;
      n++;
    end
    chk("drain", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
